video_out_load: RTL

Frame-buffer reader for the video output path: the read-side counterpart of the video input store. Given a frame base address from the processor, it fetches one frame of 8-bit pixels (four per 32-bit word) from RAM with single-word Wishbone master reads, in packets of NB_PACK pixels. Each fetched word is pushed into the output FIFO that feeds the pixel serializer. It raises an interrupt at end of frame and can loop on the same frame.

---
 rtl/video_out_load.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/video_out_load.sv
// ----------------------------------------------------------------------------
// video_out_load
// Frame-buffer reader for the video output path. On a rising edge of control
// bit 0 it latches a frame base byte address, then fetches WIDTH*HEIGHT 8-bit
// pixels (four per 32-bit word) with single-word Wishbone reads, in packets
// of NB_PACK pixels. A packet is only started once the output FIFO reports
// room for a whole packet. Each fetched word is pushed into the FIFO. At the
// end of a frame a 3-cycle interrupt is raised; in loop mode the same frame
// is fetched again.
//
// Ports
//   clk           sole clock
//   RST           synchronous active-high reset
//   wb_reg_ctr    control: bit0 rising edge = new frame, bit1 = loop mode
//   wb_reg_data   frame base byte address
//   nb_pack_free  FIFO has room for NB_PACK/4 words
//   w_en          FIFO push strobe (one cycle per word)
//   data_fifo     word pushed with w_en
//   interrupt     end-of-frame pulse (3 cycles)
//   new_addr      one-cycle restart pulse for downstream modules
//   p_wb_*        Wishbone master (read only, single-word cycles)
// ----------------------------------------------------------------------------
module video_out_load #(
   parameter int WIDTH   = 640,
   parameter int HEIGHT  = 480,
   parameter int NB_PACK = 16
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [31:0] wb_reg_ctr,
   input  logic [31:0] wb_reg_data,
   input  logic        nb_pack_free,
   output logic        w_en,
   output logic [31:0] data_fifo,
   output logic        interrupt,
   output logic        new_addr,
   output logic        p_wb_STB_O,
   output logic        p_wb_CYC_O,
   output logic        p_wb_LOCK_O,
   output logic        p_wb_WE_O,
   output logic [3:0]  p_wb_SEL_O,
   output logic [31:0] p_wb_ADR_O,
   input  logic [31:0] p_wb_DAT_I,
   input  logic        p_wb_ACK_I,
   input  logic        p_wb_ERR_I
);

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_SPACE = 3'd1;
   localparam logic [2:0] ST_READ       = 3'd2;
   localparam logic [2:0] ST_GAP        = 3'd3;
   localparam logic [2:0] ST_DONE       = 3'd4;

   // Pixel offset of the last word of the frame.
   localparam logic [19:0] FRAME_LAST = 20'(WIDTH * HEIGHT - 4);

   // Pixel offset inside the current packet is tracked separately so the
   // packet-boundary test needs no modulo on the frame counter.
   localparam int PW = (NB_PACK > 4) ? $clog2(NB_PACK) : 2;
   localparam logic [PW-1:0] PACK_LAST = PW'(NB_PACK - 4);
   localparam logic [PW-1:0] PACK_STEP = PW'(4);

   logic [2:0]    state;
   logic [19:0]   pixel_count;
   logic [PW-1:0] pack_count;
   logic [1:0]    int_cnt;
   logic [31:0]   deb_im;
   logic          old_ctr0;

   // Only bits 0 and 1 of the control register have a meaning here.
   logic ctr_unused;
   assign ctr_unused = ^wb_reg_ctr[31:2];

   // Reset masks the edge detector so that a bit0 already high during reset
   // produces exactly one pulse, in the first cycle after release.
   assign new_addr = wb_reg_ctr[0] & ~old_ctr0 & ~RST;

   // Bus controls come from registered state only; ACK never reaches them
   // combinationally.
   assign p_wb_STB_O  = (state == ST_READ);
   assign p_wb_CYC_O  = (state == ST_READ) || (state == ST_GAP);
   assign p_wb_ADR_O  = deb_im + {12'd0, pixel_count};
   assign p_wb_SEL_O  = 4'hf;
   assign p_wb_WE_O   = 1'b0;
   assign p_wb_LOCK_O = 1'b0;
   assign interrupt   = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (RST) begin
         state       <= ST_IDLE;
         pixel_count <= '0;
         pack_count  <= '0;
         int_cnt     <= '0;
         deb_im      <= '0;
         old_ctr0    <= 1'b0;
         w_en        <= 1'b0;
         data_fifo   <= '0;
      end else begin
         old_ctr0 <= wb_reg_ctr[0];
         w_en     <= 1'b0;
         if (new_addr) begin
            // Restart from any state; an ACK arriving now belongs to the
            // abandoned frame and is not pushed.
            deb_im      <= wb_reg_data;
            pixel_count <= '0;
            pack_count  <= '0;
            int_cnt     <= '0;
            state       <= ST_WAIT_SPACE;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_IDLE;
               end
               ST_WAIT_SPACE: begin
                  if (nb_pack_free)
                     state <= ST_READ;
               end
               ST_READ: begin
                  if (p_wb_ERR_I) begin
                     // Retry the same address after a one-cycle gap.
                     state <= ST_GAP;
                  end else if (p_wb_ACK_I) begin
                     w_en      <= 1'b1;
                     data_fifo <= p_wb_DAT_I;
                     if (pixel_count == FRAME_LAST) begin
                        pixel_count <= '0;
                        pack_count  <= '0;
                        state       <= ST_DONE;
                     end else begin
                        pixel_count <= pixel_count + 20'd4;
                        if (pack_count == PACK_LAST) begin
                           pack_count <= '0;
                           state      <= ST_WAIT_SPACE;
                        end else begin
                           pack_count <= pack_count + PACK_STEP;
                           state      <= ST_GAP;
                        end
                     end
                  end
               end
               ST_GAP: begin
                  state <= ST_READ;
               end
               ST_DONE: begin
                  if (int_cnt == 2'd2) begin
                     int_cnt     <= '0;
                     pixel_count <= '0;
                     state       <= wb_reg_ctr[1] ? ST_WAIT_SPACE : ST_IDLE;
                  end else begin
                     int_cnt <= int_cnt + 2'd1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
